// File: rtl/serial_addsub_pkg.sv
// Shared types and sizing helpers for the digit-serial adder/subtractor.
package serial_addsub_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic int calc_n(input int width, input int digit);
        return width / digit;
    endfunction

    // Wide enough to hold the value N itself, so the counter never wraps mid-operation.
    function automatic int cnt_width(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/serial_addsub_digit.sv
// Combinational DIGIT-bit ripple-carry slice; also exposes the carry into its top bit.
module digit_addsub #(
    parameter int DIGIT = 2
) (
    input  logic [DIGIT-1:0] a,
    input  logic [DIGIT-1:0] b,
    input  logic             cin,
    output logic [DIGIT-1:0] s,
    output logic             cout,
    output logic             c_msb
);
    logic [DIGIT:0] w_c;

    assign w_c[0] = cin;

    generate
        for (genvar gi = 0; gi < DIGIT; gi++) begin : g_bit
            assign s[gi]      = a[gi] ^ b[gi] ^ w_c[gi];
            assign w_c[gi+1]  = (a[gi] & b[gi]) | (w_c[gi] & (a[gi] ^ b[gi]));
        end
    endgenerate

    assign cout  = w_c[DIGIT];
    assign c_msb = w_c[DIGIT-1];

endmodule

// File: rtl/serial_addsub.sv
// Digit-serial add/subtract: one DIGIT-bit slice per cycle, LSB first, valid/ready on both sides.
module serial_addsub
    import serial_addsub_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DIGIT = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic             cin,
    input  logic             sub,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             zero
);
    localparam int N  = calc_n(WIDTH, DIGIT);
    localparam int CW = cnt_width(N);

    state_t           r_state;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_sum;
    logic             r_carry;
    logic [CW-1:0]    r_cnt;
    logic             r_m_valid;
    logic             r_cout;
    logic             r_ovf;
    logic             r_zero;

    logic [DIGIT-1:0] w_s;
    logic             w_cout;
    logic             w_c_msb;
    logic             w_accept;
    logic             w_last;
    logic [WIDTH-1:0] w_sum_next;

    digit_addsub #(.DIGIT(DIGIT)) u_slice (
        .a     (r_a[DIGIT-1:0]),
        .b     (r_b[DIGIT-1:0]),
        .cin   (r_carry),
        .s     (w_s),
        .cout  (w_cout),
        .c_msb (w_c_msb)
    );

    assign s_ready    = (r_state == IDLE) || ((r_state == DONE) && m_ready);
    assign w_accept   = s_valid && s_ready;
    assign w_last     = (r_cnt == CW'(N - 1));
    // Result shifts in from the top so after N slices the LSB slice sits at bit 0.
    assign w_sum_next = (r_sum >> DIGIT) | (WIDTH'(w_s) << (WIDTH - DIGIT));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= IDLE;
            r_a       <= '0;
            r_b       <= '0;
            r_sum     <= '0;
            r_carry   <= 1'b0;
            r_cnt     <= '0;
            r_m_valid <= 1'b0;
            r_cout    <= 1'b0;
            r_ovf     <= 1'b0;
            r_zero    <= 1'b1;
        end else begin
            case (r_state)
                IDLE, DONE: begin
                    if (w_accept) begin
                        r_a       <= x;
                        r_b       <= sub ? ~y : y;
                        r_carry   <= sub ? ~cin : cin;
                        r_cnt     <= '0;
                        r_m_valid <= 1'b0;
                        r_state   <= RUN;
                    end else if ((r_state == DONE) && m_ready) begin
                        r_m_valid <= 1'b0;
                        r_state   <= IDLE;
                    end
                end
                RUN: begin
                    r_sum   <= w_sum_next;
                    r_carry <= w_cout;
                    r_a     <= r_a >> DIGIT;
                    r_b     <= r_b >> DIGIT;
                    r_cnt   <= r_cnt + 1'b1;
                    if (w_last) begin
                        r_cout    <= w_cout;
                        r_ovf     <= w_c_msb ^ w_cout;
                        r_zero    <= (w_sum_next == '0);
                        r_m_valid <= 1'b1;
                        r_state   <= DONE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign m_valid = r_m_valid;
    assign sum     = r_sum;
    assign cout    = r_cout;
    assign ovf     = r_ovf;
    assign zero    = r_zero;

endmodule

// File: tb/tb_serial_addsub.sv
// Scoreboard bench: directed and random traffic on (8,2), random traffic on (8,1), (8,8), (16,4).
`timescale 1ns/1ps
module tb_serial_addsub;

    typedef struct {
        logic [15:0] sum;
        logic        cout;
        logic        ovf;
        logic        zero;
        int          accept;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Reference: plain integer arithmetic on unsigned and signed interpretations.
    function automatic exp_t ref_model(input int w, input logic [15:0] a, input logic [15:0] b,
                                       input logic ci, input logic sb);
        exp_t   r;
        longint m, ua, ub, c, sa, sbv, ures, sres;
        m   = longint'(1) << w;
        ua  = longint'(a);
        ub  = longint'(b);
        c   = longint'(ci);
        sa  = (ua >= m / 2) ? ua - m : ua;
        sbv = (ub >= m / 2) ? ub - m : ub;
        if (sb) begin
            ures   = ua - ub - c;
            sres   = sa - sbv - c;
            r.cout = (ures >= 0);
        end else begin
            ures   = ua + ub + c;
            sres   = sa + sbv + c;
            r.cout = (ures >= m);
        end
        r.ovf    = (sres < -(m / 2)) || (sres > m / 2 - 1);
        ures     = ((ures % m) + m) % m;
        r.sum    = 16'(ures);
        r.zero   = (ures == 0);
        r.accept = 0;
        return r;
    endfunction

    function automatic exp_t mk(input logic [15:0] s, input logic co, input logic ov, input logic z);
        exp_t r;
        r.sum = s; r.cout = co; r.ovf = ov; r.zero = z; r.accept = 0;
        return r;
    endfunction

    // ---------------- main instance (8,2) ----------------
    logic       a_rst, a_s_valid, a_s_ready, a_cin, a_sub, a_m_valid, a_m_ready;
    logic       a_cout, a_ovf, a_zero;
    logic [7:0] a_x, a_y, a_sum;
    exp_t       a_q[$];
    int         a_mode = 0;   // 0 always ready, 1 random, 2 stall
    bit         a_done = 0;

    serial_addsub #(.WIDTH(8), .DIGIT(2)) u_main (
        .clk(clk), .rst(a_rst), .s_valid(a_s_valid), .s_ready(a_s_ready),
        .x(a_x), .y(a_y), .cin(a_cin), .sub(a_sub),
        .m_valid(a_m_valid), .m_ready(a_m_ready),
        .sum(a_sum), .cout(a_cout), .ovf(a_ovf), .zero(a_zero)
    );

    initial begin : a_mon
        bit   seen;
        exp_t e;
        seen = 0;
        a_m_ready = 1'b1;
        forever begin
            @(negedge clk);
            a_m_ready = (a_mode == 0) ? 1'b1 : (a_mode == 1) ? 1'($urandom_range(0, 1)) : 1'b0;
            if (!a_rst && a_m_valid) begin
                if (a_q.size() == 0) begin
                    check("main_unexpected_valid", a_m_valid, 0);
                end else begin
                    e = a_q[0];
                    if (!seen) check("main_latency", cyc - e.accept, 4);
                    check("main_sum",  a_sum,  e.sum);
                    check("main_cout", a_cout, e.cout);
                    check("main_ovf",  a_ovf,  e.ovf);
                    check("main_zero", a_zero, e.zero);
                    $display("main result sum=0x%0h cout=%0b ovf=%0b zero=%0b ready=%0b",
                             a_sum, a_cout, a_ovf, a_zero, a_m_ready);
                    if (a_m_ready) void'(a_q.pop_front());
                end
                seen = (a_m_ready == 1'b0);
            end else begin
                seen = 0;
            end
        end
    end

    task automatic a_offer(input logic [7:0] xv, input logic [7:0] yv, input logic ci,
                           input logic sb, input exp_t e, output int waited);
        waited = 0;
        @(negedge clk); #1;
        a_s_valid = 1'b1; a_x = xv; a_y = yv; a_cin = ci; a_sub = sb;
        while (!a_s_ready && waited < 200) begin
            @(negedge clk); #1;
            waited++;
        end
        if (!a_s_ready) begin
            check("main_offer_timeout", a_s_ready, 1);
        end else begin
            e.accept = cyc + 1;
            a_q.push_back(e);
            $display("main issue x=0x%0h y=0x%0h cin=%0b sub=%0b", xv, yv, ci, sb);
        end
        @(posedge clk); #1;
        a_s_valid = 1'b0;
    endtask

    task automatic a_drain();
        int t = 0;
        while (a_q.size() != 0 && t < 500) begin
            @(negedge clk); #1;
            t++;
        end
        check("main_drain", a_q.size(), 0);
    endtask

    initial begin : a_drv
        int   w;
        exp_t e;
        logic [7:0] xv, yv;
        logic ci, sb;
        a_rst = 1'b1; a_s_valid = 1'b0; a_x = '0; a_y = '0; a_cin = 1'b0; a_sub = 1'b0;
        #2;
        check("rst_m_valid", a_m_valid, 0);
        check("rst_sum",     a_sum,     0);
        check("rst_cout",    a_cout,    0);
        check("rst_ovf",     a_ovf,     0);
        check("rst_zero",    a_zero,    1);
        check("rst_s_ready", a_s_ready, 1);
        repeat (2) @(negedge clk);
        #1 a_rst = 1'b0;

        a_offer(8'h7F, 8'h01, 1'b0, 1'b0, mk(16'h80, 0, 1, 0), w);
        a_offer(8'h00, 8'h01, 1'b0, 1'b1, mk(16'hFF, 0, 0, 0), w);
        a_offer(8'h80, 8'h01, 1'b0, 1'b1, mk(16'h7F, 1, 1, 0), w);
        a_offer(8'hFF, 8'h00, 1'b1, 1'b0, mk(16'h00, 1, 0, 1), w);
        a_offer(8'h10, 8'h05, 1'b1, 1'b1, mk(16'h0A, 1, 0, 0), w);
        a_offer(8'h05, 8'h05, 1'b0, 1'b1, mk(16'h00, 1, 0, 1), w);
        a_drain();

        // Stall in DONE, then release with new operands waiting.
        a_mode = 2;
        a_offer(8'h3C, 8'h0F, 1'b0, 1'b0, mk(16'h4B, 0, 0, 0), w);
        w = 0;
        while (!a_m_valid && w < 20) begin @(negedge clk); #1; w++; end
        check("stall_reached_done", a_m_valid, 1);
        repeat (5) begin
            @(negedge clk); #1;
            check("stall_s_ready", a_s_ready, 0);
            check("stall_m_valid", a_m_valid, 1);
        end
        a_mode = 0;
        a_offer(8'h01, 8'h02, 1'b0, 1'b0, mk(16'h03, 0, 0, 0), w);
        check("b2b_accept_wait", w, 0);

        // Reset during the second RUN cycle aborts the operation.
        a_offer(8'h55, 8'h0F, 1'b0, 1'b0, mk(16'h64, 0, 0, 0), w);
        @(negedge clk);
        @(negedge clk);
        #1 a_rst = 1'b1;
        a_q.delete();
        #1;
        check("abort_m_valid", a_m_valid, 0);
        check("abort_s_ready", a_s_ready, 1);
        repeat (2) @(negedge clk);
        #1 a_rst = 1'b0;
        #1 check("post_rst_s_ready", a_s_ready, 1);
        repeat (6) begin
            @(negedge clk); #1;
            check("post_rst_m_valid", a_m_valid, 0);
        end
        a_offer(8'h12, 8'h34, 1'b0, 1'b0, mk(16'h46, 0, 0, 0), w);
        a_drain();

        a_mode = 1;
        for (int i = 0; i < 60; i++) begin
            xv = 8'($urandom); yv = 8'($urandom);
            ci = 1'($urandom_range(0, 1)); sb = 1'($urandom_range(0, 1));
            e = ref_model(8, {8'h00, xv}, {8'h00, yv}, ci, sb);
            a_offer(xv, yv, ci, sb, e, w);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end
        a_drain();
        a_done = 1;
    end

    // ---------------- random-only configurations ----------------
    localparam int GW [3] = '{8, 8, 16};
    localparam int GD [3] = '{1, 8, 4};
    bit g_done [3];

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_cfg
            localparam int W = GW[gi];
            localparam int D = GD[gi];
            localparam int N = W / D;

            logic         g_rst, g_s_valid, g_s_ready, g_cin, g_sub, g_m_valid, g_m_ready;
            logic         g_cout, g_ovf, g_zero;
            logic [W-1:0] g_x, g_y, g_sum;
            exp_t         q[$];

            serial_addsub #(.WIDTH(W), .DIGIT(D)) u_dut (
                .clk(clk), .rst(g_rst), .s_valid(g_s_valid), .s_ready(g_s_ready),
                .x(g_x), .y(g_y), .cin(g_cin), .sub(g_sub),
                .m_valid(g_m_valid), .m_ready(g_m_ready),
                .sum(g_sum), .cout(g_cout), .ovf(g_ovf), .zero(g_zero)
            );

            initial begin : mon
                bit   seen;
                exp_t e;
                seen = 0;
                g_m_ready = 1'b1;
                forever begin
                    @(negedge clk);
                    g_m_ready = 1'($urandom_range(0, 2) != 0);
                    if (!g_rst && g_m_valid) begin
                        if (q.size() == 0) begin
                            check($sformatf("cfg%0d_unexpected_valid", gi), g_m_valid, 0);
                        end else begin
                            e = q[0];
                            if (!seen) check($sformatf("cfg%0d_latency", gi), cyc - e.accept, N);
                            check($sformatf("cfg%0d_sum", gi),  32'(g_sum), 32'(e.sum));
                            check($sformatf("cfg%0d_cout", gi), g_cout, e.cout);
                            check($sformatf("cfg%0d_ovf", gi),  g_ovf,  e.ovf);
                            check($sformatf("cfg%0d_zero", gi), g_zero, e.zero);
                            $display("cfg%0d result sum=0x%0h cout=%0b ovf=%0b zero=%0b ready=%0b",
                                     gi, g_sum, g_cout, g_ovf, g_zero, g_m_ready);
                            if (g_m_ready) void'(q.pop_front());
                        end
                        seen = (g_m_ready == 1'b0);
                    end else begin
                        seen = 0;
                    end
                end
            end

            initial begin : drv
                int   issued;
                int   guard;
                exp_t e;
                issued = 0; guard = 0;
                g_rst = 1'b1; g_s_valid = 1'b0; g_x = '0; g_y = '0; g_cin = 1'b0; g_sub = 1'b0;
                repeat (2) @(negedge clk);
                #1 g_rst = 1'b0;
                while (issued < 60 && guard < 5000) begin
                    @(negedge clk); #1;
                    guard++;
                    g_s_valid = 1'($urandom_range(0, 3) != 0);
                    g_x   = W'($urandom);
                    g_y   = W'($urandom);
                    g_cin = 1'($urandom_range(0, 1));
                    g_sub = 1'($urandom_range(0, 1));
                    if (g_s_valid && g_s_ready) begin
                        e = ref_model(W, 16'(g_x), 16'(g_y), g_cin, g_sub);
                        e.accept = cyc + 1;
                        q.push_back(e);
                        issued++;
                        $display("cfg%0d issue x=0x%0h y=0x%0h cin=%0b sub=%0b",
                                 gi, g_x, g_y, g_cin, g_sub);
                    end
                end
                @(negedge clk); #1 g_s_valid = 1'b0;
                guard = 0;
                while (q.size() != 0 && guard < 2000) begin
                    @(negedge clk); #1;
                    guard++;
                end
                check($sformatf("cfg%0d_drain", gi), q.size(), 0);
                g_done[gi] = 1;
            end
        end
    endgenerate

    initial begin : fin
        int t = 0;
        while (!(a_done && g_done[0] && g_done[1] && g_done[2]) && t < 40000) begin
            @(negedge clk);
            t++;
        end
        check("all_streams_finished", 32'(a_done && g_done[0] && g_done[1] && g_done[2]), 1);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/serial_addsub.md
SERIAL_ADDSUB -- requirements
Module: serial_addsub

Interface
REQ-001 Parameter WIDTH, default 8, operand/result width in bits; SHALL be >= 2.
REQ-002 Parameter DIGIT, default 2, bits processed per cycle; SHALL be >= 1 and SHALL divide WIDTH exactly.
REQ-003 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-004 rst  input  1  reset, asynchronous and active-high.
REQ-005 s_valid  input  1  operand set offered.
REQ-006 s_ready  output  1  block can accept an operand set this cycle.
REQ-007 x  input  WIDTH  operand A.
REQ-008 y  input  WIDTH  operand B.
REQ-009 cin  input  1  carry-in for add, borrow-in for subtract.
REQ-010 sub  input  1  mode: 0 = add, 1 = subtract.
REQ-011 m_valid  output  1  result available.
REQ-012 m_ready  input  1  consumer accepts the result.
REQ-013 sum  output  WIDTH  result.
REQ-014 cout  output  1  final carry; in subtract mode 1 = no borrow.
REQ-015 ovf  output  1  signed two's-complement overflow.
REQ-016 zero  output  1  high when sum == 0.

Function
REQ-017 Transfers SHALL occur on s_valid&&s_ready (input) and m_valid&&m_ready (output).
REQ-018 FSM states SHALL be IDLE, RUN, DONE.
REQ-019 IDLE: s_ready=1; on input transfer, latch x, y, sub, cin; go to RUN.
REQ-020 Initial carry SHALL be cin when sub=0 and ~cin when sub=1; y SHALL be bitwise inverted when sub=1. Result = x+y+cin (add) or x-y-cin (subtract), modulo 2^WIDTH.
REQ-021 RUN: each cycle, add one DIGIT-bit slice, LSB slice first; store the slice sum and carry. After N = WIDTH/DIGIT cycles, go to DONE.
REQ-022 m_valid SHALL rise exactly N cycles after the input-transfer edge. Example: with WIDTH=8 and DIGIT=2, m_valid is high in the 4th cycle after acceptance.
REQ-023 Outputs and flags:
- cout = carry out of the MSB.
- ovf = carry into the MSB XOR carry out of the MSB.
- zero = (sum == 0).
All SHALL be registered and valid whenever m_valid=1.
REQ-024 DONE: m_valid=1. sum, cout, ovf and zero SHALL be held stable until the output transfer.
REQ-025 DONE with m_ready=0: s_ready=0 and the state SHALL remain DONE.
REQ-026 DONE with m_ready=1: s_ready=1.
- If s_valid=1, the new operands are accepted in the same cycle and the state goes to RUN (back-to-back, no bubble).
- Otherwise the state goes to IDLE.
REQ-027 RUN: s_ready=0 and m_valid=0. Input changes and s_valid SHALL be ignored.
REQ-028 When DIGIT == WIDTH, N=1 and RUN SHALL last exactly one cycle.
REQ-029 The slice counter SHALL be ceil(log2(N+1)) bits wide. It SHALL reset to 0 on each acceptance and SHALL NOT wrap inside an operation.

Reset
REQ-030 Asserting rst SHALL immediately force:
- state = IDLE
- m_valid = 0
- sum, cout, ovf = 0
- zero = 1
- counter = 0
- carry = 0
REQ-031 rst asserted mid-RUN or mid-DONE SHALL abort the operation with no partial result presented.
REQ-032 After rst deasserts, s_ready SHALL be 1 in the first cycle.

Structure
REQ-033 A shared package SHALL hold:
- the FSM state enum (IDLE, RUN, DONE)
- a function computing N from WIDTH and DIGIT
- the counter-width constant function
REQ-034 A single sub-module, digit_addsub, SHALL implement the combinational DIGIT-bit ripple slice. It SHALL be parametrised by DIGIT and expose:
- inputs a, b, cin
- outputs s, cout, and carry-into-MSB (c_msb)
REQ-035 serial_addsub SHALL instantiate exactly one digit_addsub and reuse it every RUN cycle.

Verification (WIDTH=8, DIGIT=2 unless stated)
REQ-036 Add 0x7F+0x01, cin=0 -> after 4 cycles: sum=0x80, cout=0, ovf=1, zero=0.
REQ-037 Subtract 0x00-0x01, cin=0 -> sum=0xFF, cout=0, ovf=0. Subtract 0x80-0x01 -> sum=0x7F, cout=1, ovf=1.
REQ-038 Add 0xFF+0x00, cin=1 -> sum=0x00, cout=1, zero=1.
REQ-039 Hold m_ready=0 for 5 cycles in DONE -> outputs stable, s_ready=0. Then m_ready=1 with s_valid=1 -> new operands accepted that same cycle.
REQ-040 Assert rst during the 2nd RUN cycle -> m_valid stays 0, s_ready=1 after release, and a subsequent 0x12+0x34 gives 0x46.
REQ-041 Random add/sub vs a reference model for (WIDTH,DIGIT) in {(8,1),(8,8),(16,4)} -> all fields match and latency = N for every case.
